// File: rtl/tc_mul_ctrl_track_if.sv
// Handshake and data bundle between the tc_mul control tracker, the issue side,
// the tc_mul lane array and the accumulate stage.
interface tc_mul_ctrl_track_if #(
  parameter int SHAPE_K       = 8,
  parameter int ELEMENT_WIDTH = 9,
  parameter int CTRL_C_WIDTH  = 16,
  parameter int DEPTH_WARP    = 4,
  parameter int FIFO_DEPTH    = 4
);
  localparam int RES_W = SHAPE_K * ELEMENT_WIDTH;
  localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;

  logic                    in_valid_i;
  logic                    in_ready_o;
  logic [2:0]              rm_i;
  logic [CTRL_C_WIDTH-1:0] ctrl_c_i;
  logic [2:0]              ctrl_rm_i;
  logic [7:0]              ctrl_reg_idxw_i;
  logic [DEPTH_WARP-1:0]   ctrl_warpid_i;
  logic                    mul_in_valid_o;
  logic                    mul_in_ready_i;
  logic [2:0]              mul_rm_o;
  logic                    mul_out_valid_i;
  logic                    mul_out_ready_o;
  logic [RES_W-1:0]        mul_result_i;
  logic [4:0]              mul_fflags_i;
  logic                    out_valid_o;
  logic                    out_ready_i;
  logic [RES_W-1:0]        result_o;
  logic [4:0]              fflags_o;
  logic [CTRL_C_WIDTH-1:0] ctrl_c_o;
  logic [2:0]              ctrl_rm_o;
  logic [7:0]              ctrl_reg_idxw_o;
  logic [DEPTH_WARP-1:0]   ctrl_warpid_o;
  logic [OCC_W-1:0]        occupancy_o;
  logic                    orphan_o;

  modport slave (
    input  in_valid_i, rm_i, ctrl_c_i, ctrl_rm_i, ctrl_reg_idxw_i, ctrl_warpid_i,
           mul_in_ready_i, mul_out_valid_i, mul_result_i, mul_fflags_i, out_ready_i,
    output in_ready_o, mul_in_valid_o, mul_rm_o, mul_out_ready_o, out_valid_o,
           result_o, fflags_o, ctrl_c_o, ctrl_rm_o, ctrl_reg_idxw_o, ctrl_warpid_o,
           occupancy_o, orphan_o
  );

  modport master (
    output in_valid_i, rm_i, ctrl_c_i, ctrl_rm_i, ctrl_reg_idxw_i, ctrl_warpid_i,
           mul_in_ready_i, mul_out_valid_i, mul_result_i, mul_fflags_i, out_ready_i,
    input  in_ready_o, mul_in_valid_o, mul_rm_o, mul_out_ready_o, out_valid_o,
           result_o, fflags_o, ctrl_c_o, ctrl_rm_o, ctrl_reg_idxw_o, ctrl_warpid_o,
           occupancy_o, orphan_o
  );
endinterface

// File: rtl/tc_mul_ctrl_track.sv
// Carries the control tag of each tc_mul request through an in-order FIFO and
// re-joins it with the returned product in a registered one-entry output stage.
module tc_mul_ctrl_track #(
  parameter int SHAPE_K       = 8,
  parameter int ELEMENT_WIDTH = 9,
  parameter int CTRL_C_WIDTH  = 16,
  parameter int DEPTH_WARP    = 4,
  parameter int FIFO_DEPTH    = 4
) (
  input logic               clk,
  input logic               rst,
  tc_mul_ctrl_track_if.slave bus
);
  localparam int RES_W = SHAPE_K * ELEMENT_WIDTH;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam int TAG_W = CTRL_C_WIDTH + 3 + 8 + DEPTH_WARP;

  logic [TAG_W-1:0] r_tag_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [OCC_W-1:0] r_occ;
  logic             r_out_valid;
  logic [RES_W-1:0] r_result;
  logic [4:0]       r_fflags;
  logic [TAG_W-1:0] r_tag;
  logic             r_orphan;

  logic             w_full;
  logic             w_empty;
  logic             w_in_ready;
  logic             w_push;
  logic             w_mul_out_ready;
  logic             w_capture;
  logic             w_pop;
  logic [TAG_W-1:0] w_tag_in;

  // A full FIFO blocks pushes even when a pop lands in the same cycle.
  assign w_full          = (r_occ == OCC_W'(FIFO_DEPTH));
  assign w_empty         = (r_occ == '0);
  assign w_in_ready      = bus.mul_in_ready_i & ~w_full;
  assign w_push          = bus.in_valid_i & w_in_ready;
  assign w_mul_out_ready = ~r_out_valid | bus.out_ready_i;
  assign w_capture       = bus.mul_out_valid_i & w_mul_out_ready;
  assign w_pop           = w_capture & ~w_empty;
  assign w_tag_in        = {bus.ctrl_c_i, bus.ctrl_rm_i, bus.ctrl_reg_idxw_i, bus.ctrl_warpid_i};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + OCC_W'(1);
        2'b01:   r_occ <= r_occ - OCC_W'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_tag_mem[i] <= '0;
    end else if (w_push) begin
      r_tag_mem[r_wr_ptr] <= w_tag_in;
    end
  end

  // A return with nothing queued still produces an output, tagged 0, and latches orphan.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_fflags    <= '0;
      r_tag       <= '0;
      r_orphan    <= 1'b0;
    end else begin
      if (w_capture) begin
        r_out_valid <= 1'b1;
        r_result    <= bus.mul_result_i;
        r_fflags    <= bus.mul_fflags_i;
        r_tag       <= w_empty ? '0 : r_tag_mem[r_rd_ptr];
      end else if (bus.out_ready_i) begin
        r_out_valid <= 1'b0;
      end
      r_orphan <= r_orphan | (w_capture & w_empty);
    end
  end

  assign bus.in_ready_o      = w_in_ready;
  assign bus.mul_in_valid_o  = bus.in_valid_i & ~w_full;
  assign bus.mul_rm_o        = bus.rm_i;
  assign bus.mul_out_ready_o = w_mul_out_ready;
  assign bus.out_valid_o     = r_out_valid;
  assign bus.result_o        = r_result;
  assign bus.fflags_o        = r_fflags;
  assign bus.ctrl_c_o        = r_tag[TAG_W-1 -: CTRL_C_WIDTH];
  assign bus.ctrl_rm_o       = r_tag[DEPTH_WARP+8 +: 3];
  assign bus.ctrl_reg_idxw_o = r_tag[DEPTH_WARP +: 8];
  assign bus.ctrl_warpid_o   = r_tag[DEPTH_WARP-1:0];
  assign bus.occupancy_o     = r_occ;
  assign bus.orphan_o        = r_orphan;
endmodule

// File: tb/tb_tc_mul_ctrl_track.sv
// Directed bench for tc_mul_ctrl_track: the bench plays both the issue side and tc_mul.
module tb_tc_mul_ctrl_track;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  tc_mul_ctrl_track_if bus ();
  tc_mul_ctrl_track dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [3:0]  warpid;
    logic [7:0]  reg_idxw;
    logic [15:0] ctrl_c;
    logic [2:0]  ctrl_rm;
    logic [2:0]  rm;
    logic [71:0] result;
    logic [4:0]  fflags;
    logic [3:0]  exp_warpid;
    logic [7:0]  exp_reg_idxw;
    logic [15:0] exp_ctrl_c;
    logic [2:0]  exp_ctrl_rm;
    logic [2:0]  exp_mul_rm;
    logic [71:0] exp_result;
    logic [4:0]  exp_fflags;
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid_i      = 1'b0;
    bus.rm_i            = 3'd0;
    bus.ctrl_c_i        = 16'h0;
    bus.ctrl_rm_i       = 3'd0;
    bus.ctrl_reg_idxw_i = 8'h0;
    bus.ctrl_warpid_i   = 4'h0;
    bus.mul_in_ready_i  = 1'b1;
    bus.mul_out_valid_i = 1'b0;
    bus.mul_result_i    = 72'h0;
    bus.mul_fflags_i    = 5'h0;
    bus.out_ready_i     = 1'b1;
  endtask

  task automatic push(input logic [3:0] w);
    bus.in_valid_i    = 1'b1;
    bus.ctrl_warpid_i = w;
    tick();
    bus.in_valid_i    = 1'b0;
  endtask

  initial begin
    int pushed;
    int returned;
    int gap;
    logic do_push;
    logic do_ret;

    vecs[0] = '{4'd5, 8'h12, 16'hBEEF, 3'd1, 3'd2, 72'hFFFFFFFFFFFFFFFFFF, 5'h01,
                4'd5, 8'h12, 16'hBEEF, 3'd1, 3'd2, 72'hFFFFFFFFFFFFFFFFFF, 5'h01};
    vecs[1] = '{4'd15, 8'hFF, 16'hFFFF, 3'd7, 3'd7, 72'h123456789ABCDEF012, 5'h1F,
                4'd15, 8'hFF, 16'hFFFF, 3'd7, 3'd7, 72'h123456789ABCDEF012, 5'h1F};
    vecs[2] = '{4'd0, 8'h00, 16'h0001, 3'd0, 3'd4, 72'h000000000000000001, 5'h00,
                4'd0, 8'h00, 16'h0001, 3'd0, 3'd4, 72'h000000000000000001, 5'h00};
    vecs[3] = '{4'd10, 8'hA5, 16'h8000, 3'd4, 3'd3, 72'hA5A5A5A5A5A5A5A5A5, 5'h10,
                4'd10, 8'hA5, 16'h8000, 3'd4, 3'd3, 72'hA5A5A5A5A5A5A5A5A5, 5'h10};

    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_occ", bus.occupancy_o, 72'd0);
    chk("rst_out_valid", bus.out_valid_o, 72'd0);
    chk("rst_result", bus.result_o, 72'd0);
    chk("rst_fflags", bus.fflags_o, 72'd0);
    chk("rst_ctrl_c", bus.ctrl_c_o, 72'd0);
    chk("rst_warpid", bus.ctrl_warpid_o, 72'd0);
    chk("rst_orphan", bus.orphan_o, 72'd0);
    rst = 1'b0;
    chk("idle_in_ready", bus.in_ready_o, 72'd1);

    // Orphan return: empty FIFO, tag comes out as zero and orphan latches
    bus.mul_out_valid_i = 1'b1;
    bus.mul_result_i    = 72'h0AB;
    bus.mul_fflags_i    = 5'h3;
    tick();
    bus.mul_out_valid_i = 1'b0;
    chk("orph_valid", bus.out_valid_o, 72'd1);
    chk("orph_result", bus.result_o, 72'h0AB);
    chk("orph_warpid", bus.ctrl_warpid_o, 72'd0);
    chk("orph_ctrl_c", bus.ctrl_c_o, 72'd0);
    chk("orph_flag", bus.orphan_o, 72'd1);
    chk("orph_occ", bus.occupancy_o, 72'd0);
    tick();
    chk("orph_drain", bus.out_valid_o, 72'd0);
    chk("orph_sticky", bus.orphan_o, 72'd1);

    // Async reset with 3 tags queued
    push(4'd1);
    push(4'd2);
    push(4'd3);
    chk("pre_rst_occ", bus.occupancy_o, 72'd3);
    #2 rst = 1'b1;
    #1;
    chk("arst_occ", bus.occupancy_o, 72'd0);
    chk("arst_valid", bus.out_valid_o, 72'd0);
    chk("arst_orphan", bus.orphan_o, 72'd0);
    tick();
    rst = 1'b0;

    // Table-driven single operations
    for (int i = 0; i < 4; i++) begin
      bus.in_valid_i      = 1'b1;
      bus.rm_i            = vecs[i].rm;
      bus.ctrl_warpid_i   = vecs[i].warpid;
      bus.ctrl_reg_idxw_i = vecs[i].reg_idxw;
      bus.ctrl_c_i        = vecs[i].ctrl_c;
      bus.ctrl_rm_i       = vecs[i].ctrl_rm;
      #1;
      chk("vec_mul_rm", bus.mul_rm_o, 72'(vecs[i].exp_mul_rm));
      chk("vec_mul_in_valid", bus.mul_in_valid_o, 72'd1);
      tick();
      idle_inputs();
      chk("vec_occ_push", bus.occupancy_o, 72'd1);
      bus.mul_out_valid_i = 1'b1;
      bus.mul_result_i    = vecs[i].result;
      bus.mul_fflags_i    = vecs[i].fflags;
      tick();
      bus.mul_out_valid_i = 1'b0;
      bus.mul_result_i    = 72'h0;
      chk("vec_valid", bus.out_valid_o, 72'd1);
      chk("vec_result", bus.result_o, vecs[i].exp_result);
      chk("vec_fflags", bus.fflags_o, 72'(vecs[i].exp_fflags));
      chk("vec_warpid", bus.ctrl_warpid_o, 72'(vecs[i].exp_warpid));
      chk("vec_reg_idxw", bus.ctrl_reg_idxw_o, 72'(vecs[i].exp_reg_idxw));
      chk("vec_ctrl_c", bus.ctrl_c_o, 72'(vecs[i].exp_ctrl_c));
      chk("vec_ctrl_rm", bus.ctrl_rm_o, 72'(vecs[i].exp_ctrl_rm));
      chk("vec_occ_pop", bus.occupancy_o, 72'd0);
      tick();
      chk("vec_drain", bus.out_valid_o, 72'd0);
      chk("vec_hold", bus.result_o, vecs[i].exp_result);
    end

    // Fill to FIFO_DEPTH, then a return with in_valid still high (no push bypass)
    for (int i = 0; i < 4; i++) push(4'(i));
    bus.in_valid_i    = 1'b1;
    bus.ctrl_warpid_i = 4'd4;
    #1;
    chk("full_occ", bus.occupancy_o, 72'd4);
    chk("full_in_ready", bus.in_ready_o, 72'd0);
    chk("full_mul_in_valid", bus.mul_in_valid_o, 72'd0);
    tick();
    chk("full_blocked_occ", bus.occupancy_o, 72'd4);
    bus.mul_out_valid_i = 1'b1;
    bus.mul_result_i    = 72'h100;
    tick();
    bus.in_valid_i      = 1'b0;
    bus.mul_out_valid_i = 1'b0;
    chk("fill_pop_occ", bus.occupancy_o, 72'd3);
    chk("fill_in_ready", bus.in_ready_o, 72'd1);
    chk("fill_out_warpid", bus.ctrl_warpid_o, 72'd0);

    // Back-pressure: held output, blocked return, then back-to-back drain
    bus.out_ready_i     = 1'b0;
    bus.mul_out_valid_i = 1'b1;
    bus.mul_result_i    = 72'h101;
    #1;
    chk("bp_mul_out_ready", bus.mul_out_ready_o, 72'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", bus.out_valid_o, 72'd1);
      chk("bp_result", bus.result_o, 72'h100);
      chk("bp_warpid", bus.ctrl_warpid_o, 72'd0);
    end
    chk("bp_occ", bus.occupancy_o, 72'd3);
    bus.out_ready_i = 1'b1;
    #1;
    chk("bp_release_ready", bus.mul_out_ready_o, 72'd1);
    for (int i = 1; i <= 3; i++) begin
      bus.mul_result_i = 72'(256 + i);
      tick();
      chk("b2b_valid", bus.out_valid_o, 72'd1);
      chk("b2b_warpid", bus.ctrl_warpid_o, 72'(i));
      chk("b2b_result", bus.result_o, 72'(256 + i));
    end
    bus.mul_out_valid_i = 1'b0;
    tick();
    chk("b2b_drain", bus.out_valid_o, 72'd0);
    chk("b2b_occ", bus.occupancy_o, 72'd0);

    // Ordering across pointer wrap: 10 ops with random return gaps
    pushed   = 0;
    returned = 0;
    gap      = int'($urandom_range(0, 3));
    for (int cyc = 0; cyc < 300 && returned < 10; cyc++) begin
      do_push = (pushed < 10) && bus.in_ready_o;
      do_ret  = (returned < pushed) && (gap == 0);
      bus.in_valid_i      = (pushed < 10);
      bus.ctrl_warpid_i   = 4'(pushed);
      bus.mul_out_valid_i = do_ret;
      bus.mul_result_i    = 72'(500 + returned);
      if (!do_ret && gap > 0) gap--;
      tick();
      if (do_push) pushed++;
      if (do_ret) begin
        chk("order_warpid", bus.ctrl_warpid_o, 72'(returned));
        chk("order_result", bus.result_o, 72'(500 + returned));
        returned++;
        gap = int'($urandom_range(0, 3));
      end
    end
    bus.in_valid_i      = 1'b0;
    bus.mul_out_valid_i = 1'b0;
    chk("order_count", 72'(returned), 72'd10);
    tick();
    chk("order_occ", bus.occupancy_o, 72'd0);
    chk("order_orphan", bus.orphan_o, 72'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
